test_status_monitor: RTL and testbench
======================================

Name: test_status_monitor

Overview:
Synthesizable end-of-test monitor for simulation and FPGA harnesses. It generalises the testbench completion logic (cycle count, max-cycle timeout, dump-start trigger, success/failure) to NUM_CH independently maskable channels. It adds a per-channel progress watchdog, a post-reset holdoff and a latched pass/fail verdict with reason code and failing-channel index. It sits between the harness success/failure sources and the test driver, which only polls done/pass.

Parameters:
NUM_CH, 4, number of monitored channels (1..32)
CNT_W, 64, width of cycle counter and cycle-valued config
WD_W, 32, width of per-channel watchdog counters and limit
HOLDOFF, 8, cycles after reset release before channel inputs are sampled (>=1)
CH_IDX_W, max(1,$clog2(NUM_CH)), width of fail_ch (derived localparam)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous active-low reset (0 = in reset); deassertion is synchronous to clock upstream
cfg_max_cycles  in  CNT_W  timeout limit; 0 disables
cfg_wd_limit  in  WD_W  watchdog limit in cycles; 0 disables
cfg_dump_start  in  CNT_W  cycle at which dump_on asserts
ch_mask  in  NUM_CH  1 = channel monitored
ch_success  in  NUM_CH  per-channel success, level or pulse
ch_failure  in  NUM_CH  per-channel failure, level or pulse
ch_heartbeat  in  NUM_CH  per-channel progress pulse
run  out  1  high while in RUN
dump_on  out  1  waveform dump enable
done  out  1  verdict reached (sticky)
pass  out  1  verdict is pass (valid when done)
fail_reason  out  2  0 none, 1 channel failure, 2 timeout, 3 watchdog
fail_ch  out  CH_IDX_W  lowest failing/stalled channel index (0 for timeout)
cycle_count  out  CNT_W  cycles since reset release

Behaviour:
- Reset (reset=0): state=HOLD; cycle_count=0; hold counter=0; success latches=0; watchdog counters=0. Outputs run=0, dump_on=0, done=0, pass=0, fail_reason=0, fail_ch=0. Reset mid-test aborts and fully reinitialises.
- cycle_count increments every cycle in HOLD and RUN. It saturates at all-ones and freezes in PASS/FAIL.
- FSM HOLD -> RUN after HOLDOFF cycles. In HOLD, ch_* inputs are ignored and watchdogs are held at 0.
- RUN -> FAIL or PASS, evaluated each cycle in this priority:
  1. Any ch_failure & ch_mask: reason 1, fail_ch = lowest set index.
  2. cfg_max_cycles!=0 and cycle_count >= cfg_max_cycles: reason 2.
  3. cfg_wd_limit!=0 and any masked watchdog counter == cfg_wd_limit: reason 3, fail_ch = lowest such index.
  4. ch_mask!=0 and (succ_latch | ch_success) covers ch_mask: PASS.
- Verdict registers on the next edge: done=1; pass=1 only for PASS. PASS and FAIL are terminal until reset.
- Success latches are sticky per channel, set in RUN on ch_success. Success and failure on the same channel in the same cycle: failure wins.
- Watchdog counter per channel: clears on heartbeat, otherwise increments, saturating at cfg_wd_limit. Unmasked channels are held at 0. A heartbeat in the cycle the counter would hit the limit clears it (no fire).
- ch_mask=0: never passes; only a timeout can end the test.
- dump_on sets when cycle_count == cfg_dump_start (any state before verdict). It clears on the edge where done sets and stays 0 afterwards.
- Config and ch_mask are sampled live; they are specified as stable from HOLD onward.

Decomposition:
- Package test_status_pkg: state enum {HOLD, RUN, PASS, FAIL}; reason enum {RSN_NONE=0, RSN_CHFAIL=1, RSN_TIMEOUT=2, RSN_WDOG=3}; lowest-set-index function.
- Sub-module test_status_wdog: one channel's watchdog counter (clock, reset, en, heartbeat, limit, expired), instantiated NUM_CH times via generate.

Test Plan:
- HOLDOFF=8, mask=4'b0011, success on ch0 at cycle 20 and ch1 at cycle 30 -> done=1, pass=1 at cycle_count 31, reason 0; no earlier done.
- mask=4'b1111, ch_failure[2] and ch_failure[1] in the same cycle at cycle 15 -> pass=0, reason 1, fail_ch=1. Also ch_success[3] in the same cycle → still FAIL.
- cfg_max_cycles=100, no success -> done at cycle_count 101 with reason 2, fail_ch=0; cycle_count frozen afterwards. cfg_max_cycles=0 -> no timeout after 10000 cycles.
- cfg_wd_limit=5, ch0 heartbeat every 4 cycles, ch3 silent from cycle 10 -> reason 3, fail_ch=3. Heartbeat every 5th cycle (limit-1 gap) → no fire.
- cfg_dump_start=12 -> dump_on rises when cycle_count==12 and falls with done. cfg_dump_start=0 -> dump_on high from first cycle after reset.
- Assert reset low mid-RUN at cycle 40 with success latched -> all outputs return to reset values immediately (asynchronously). After release, HOLD repeats and old success latches are not honoured.

Source files
------------

// File: rtl/test_status_pkg.sv
// Shared types and helpers for the end-of-test status monitor.
package test_status_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RSN_NONE    = 2'd0,
    RSN_CHFAIL  = 2'd1,
    RSN_TIMEOUT = 2'd2,
    RSN_WDOG    = 2'd3
  } reason_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [4:0] lowest_set(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/test_status_wdog.sv
// Single-channel progress watchdog: counts cycles since the last heartbeat,
// saturating at the limit, and flags expiry when the limit is reached.
module test_status_wdog
  import test_status_pkg::*;
#(
  parameter int WD_W = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic            heartbeat,
  input  logic [WD_W-1:0] limit,
  output logic            expired
);

  logic [WD_W-1:0] r_cnt;

  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] cnt,
                                               input logic [WD_W-1:0] lim);
    return (cnt >= lim) ? cnt : cnt + WD_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!en || heartbeat) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= sat_inc(r_cnt, limit);
    end
  end

  assign expired = en && (limit != '0) && (r_cnt == limit);

endmodule

// File: rtl/test_status_monitor.sv
// End-of-test monitor: holdoff after reset, then per-channel success/failure,
// timeout and watchdog evaluation into a sticky pass/fail verdict.
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 64,
  parameter int WD_W    = 32,
  parameter int HOLDOFF = 8,
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CNT_W-1:0]    cfg_max_cycles,
  input  logic [WD_W-1:0]     cfg_wd_limit,
  input  logic [CNT_W-1:0]    cfg_dump_start,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [NUM_CH-1:0]   ch_success,
  input  logic [NUM_CH-1:0]   ch_failure,
  input  logic [NUM_CH-1:0]   ch_heartbeat,
  output logic                run,
  output logic                dump_on,
  output logic                done,
  output logic                pass,
  output logic [1:0]          fail_reason,
  output logic [CH_IDX_W-1:0] fail_ch,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam int HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cycle;
  logic [HOLD_W-1:0]   r_hold;
  logic [NUM_CH-1:0]   r_succ;
  logic                r_dump;
  logic                r_done;
  logic                r_pass;
  reason_t             r_reason;
  logic [CH_IDX_W-1:0] r_fail_ch;

  logic                w_run;
  logic [NUM_CH-1:0]   w_wd_exp;
  logic [NUM_CH-1:0]   w_fail_vec;
  logic [NUM_CH-1:0]   w_wd_vec;
  logic [NUM_CH-1:0]   w_succ_all;
  logic                w_verdict;
  logic                w_pass_now;
  reason_t             w_reason;
  logic [CH_IDX_W-1:0] w_fail_ch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_run = (r_state == RUN);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
    test_status_wdog #(.WD_W(WD_W)) u_wdog (
      .clock     (clock),
      .reset     (reset),
      .en        (w_run && ch_mask[g]),
      .heartbeat (ch_heartbeat[g]),
      .limit     (cfg_wd_limit),
      .expired   (w_wd_exp[g])
    );
  end

  // Verdict priority: channel failure, timeout, watchdog, then pass.
  always_comb begin
    w_fail_vec = ch_failure & ch_mask;
    w_wd_vec   = w_wd_exp & ch_mask;
    w_succ_all = r_succ | ch_success;
    w_verdict  = 1'b0;
    w_pass_now = 1'b0;
    w_reason   = RSN_NONE;
    w_fail_ch  = '0;
    if (w_run) begin
      if (|w_fail_vec) begin
        w_verdict = 1'b1;
        w_reason  = RSN_CHFAIL;
        w_fail_ch = CH_IDX_W'(lowest_set(32'(w_fail_vec)));
      end else if ((cfg_max_cycles != '0) && (r_cycle >= cfg_max_cycles)) begin
        w_verdict = 1'b1;
        w_reason  = RSN_TIMEOUT;
      end else if (|w_wd_vec) begin
        w_verdict = 1'b1;
        w_reason  = RSN_WDOG;
        w_fail_ch = CH_IDX_W'(lowest_set(32'(w_wd_vec)));
      end else if ((ch_mask != '0) && ((w_succ_all & ch_mask) == ch_mask)) begin
        w_verdict  = 1'b1;
        w_pass_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= HOLD;
      r_cycle   <= '0;
      r_hold    <= '0;
      r_succ    <= '0;
      r_dump    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_reason  <= RSN_NONE;
      r_fail_ch <= '0;
    end else begin
      if ((r_state == HOLD) || (r_state == RUN)) begin
        r_cycle <= sat_inc(r_cycle);
      end
      case (r_state)
        HOLD: begin
          r_hold <= r_hold + HOLD_W'(1);
          if (r_hold == HOLD_LAST) r_state <= RUN;
        end
        RUN: begin
          r_succ <= r_succ | ch_success;
          if (w_verdict) begin
            r_state   <= w_pass_now ? PASS : FAIL;
            r_done    <= 1'b1;
            r_pass    <= w_pass_now;
            r_reason  <= w_reason;
            r_fail_ch <= w_fail_ch;
          end
        end
        default: ;
      endcase
      // Dump window closes on the verdict edge and never reopens.
      if (w_verdict) begin
        r_dump <= 1'b0;
      end else if (!r_done && (r_cycle == cfg_dump_start)) begin
        r_dump <= 1'b1;
      end
    end
  end

  assign run         = w_run;
  assign dump_on     = r_dump;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail_reason = r_reason;
  assign fail_ch     = r_fail_ch;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_test_status_monitor.sv
// Scoreboard bench for test_status_monitor: directed plan scenarios plus
// randomized scenarios scored by a cycle-indexed reference model.
module tb_test_status_monitor;

  localparam int NUM_CH  = 4;
  localparam int HOLDOFF = 8;
  localparam int MAXLEN  = 10100;

  typedef struct {
    longint dcc;
    bit     p;
    int     r;
    int     ch;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] g_max = '0;
  logic [31:0] g_wdl = '0;
  logic [63:0] g_dump = '0;
  logic [3:0]  g_mask = '0;
  logic [3:0]  ch_success = '0, ch_failure = '0, ch_heartbeat = '0;
  logic        run, dump_on, done, pass;
  logic [1:0]  fail_reason, fail_ch;
  logic [63:0] cycle_count;

  logic [3:0] a_succ[MAXLEN];
  logic [3:0] a_fail[MAXLEN];
  logic [3:0] a_hb[MAXLEN];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

  test_status_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(64), .WD_W(32), .HOLDOFF(HOLDOFF)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_max_cycles(g_max), .cfg_wd_limit(g_wdl), .cfg_dump_start(g_dump),
    .ch_mask(g_mask), .ch_success(ch_success), .ch_failure(ch_failure),
    .ch_heartbeat(ch_heartbeat),
    .run(run), .dump_on(dump_on), .done(done), .pass(pass),
    .fail_reason(fail_reason), .fail_ch(fail_ch), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: scores the verdict whenever done rises.
  always @(negedge clock) begin
    if (reset && done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("verdict_cycle", cycle_count, 64'(e.dcc));
        check("verdict_pass", 64'(pass), 64'(e.p));
        check("verdict_reason", 64'(fail_reason), 64'(e.r));
        check("verdict_ch", 64'(fail_ch), 64'(e.ch));
      end
    end
    prev_done <= done;
  end

  task automatic check_zero(input string tag);
    check({tag, "_run"}, 64'(run), 0);
    check({tag, "_dump"}, 64'(dump_on), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_pass"}, 64'(pass), 0);
    check({tag, "_reason"}, 64'(fail_reason), 0);
    check({tag, "_ch"}, 64'(fail_ch), 0);
    check({tag, "_count"}, cycle_count, 0);
  endtask

  task automatic clear_stim(input int len);
    for (int c = 0; c < len; c++) begin
      a_succ[c] = '0;
      a_fail[c] = '0;
      a_hb[c]   = '0;
    end
  endtask

  // Reference model: scans cycles after the holdoff and applies the verdict
  // rules directly; a watchdog count is "cycles since last heartbeat".
  task automatic model(input int len, output bit v, output longint dcc,
                       output bit p, output int r, output int ch);
    longint   s[NUM_CH];
    longint   cnt;
    logic [3:0] seen, fv;
    int       wch;
    v = 0; dcc = 0; p = 0; r = 0; ch = 0; seen = '0;
    for (int i = 0; i < NUM_CH; i++) s[i] = HOLDOFF;
    for (int c = HOLDOFF; c < len && !v; c++) begin
      seen = seen | a_succ[c];
      fv   = a_fail[c] & g_mask;
      wch  = -1;
      if (fv != 0) begin
        v = 1; r = 1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (fv[i]) ch = i;
      end else if (g_max != 0 && 64'(c) >= g_max) begin
        v = 1; r = 2;
      end else begin
        if (g_wdl != 0) begin
          for (int i = 0; i < NUM_CH; i++) begin
            cnt = longint'(c) - s[i];
            if (cnt > longint'(g_wdl)) cnt = longint'(g_wdl);
            if (g_mask[i] && wch < 0 && cnt == longint'(g_wdl)) wch = i;
          end
        end
        if (wch >= 0) begin
          v = 1; r = 3; ch = wch;
        end else if (g_mask != 0 && (seen & g_mask) == g_mask) begin
          v = 1; p = 1;
        end
      end
      if (v) dcc = c + 1;
      for (int i = 0; i < NUM_CH; i++) if (a_hb[c][i]) s[i] = c + 1;
    end
  endtask

  // Reset, release, then drive one stimulus vector per cycle and check
  // cycle_count/run/done/dump_on against the expected timeline.
  task automatic run_test(input int ncyc, input int abort_at, input bit ev,
                          input longint dcc, input bit ep, input int er, input int ech);
    int     k;
    int     kend;
    bit     aborted;
    bit     done_e;
    exp_t   e;
    reset = 1'b0;
    ch_success = '0; ch_failure = '0; ch_heartbeat = '0;
    repeat (2) @(negedge clock);
    check_zero("rst");
    if (ev) begin
      e.dcc = dcc; e.p = ep; e.r = er; e.ch = ech;
      exp_q.push_back(e);
    end
    kend = ev ? int'(dcc) + 20 : ncyc;
    aborted = 0;
    k = 0;
    reset = 1'b1;
    while (k < kend && !aborted) begin
      done_e = ev && (longint'(k) >= dcc);
      check("cycle_count", cycle_count, done_e ? 64'(dcc) : 64'(k));
      check("run", 64'(run), 64'((k >= HOLDOFF) && !done_e));
      check("done", 64'(done), 64'(done_e));
      check("dump_on", 64'(dump_on), 64'(!done_e && (g_dump < 64'(k))));
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        aborted = 1;
      end else begin
        ch_success   = (k < ncyc) ? a_succ[k] : '0;
        ch_failure   = (k < ncyc) ? a_fail[k] : '0;
        ch_heartbeat = (k < ncyc) ? a_hb[k]   : '0;
        @(negedge clock);
        k++;
      end
    end
    check("verdict_seen", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic rand_noise(input int len, input int psucc, input int pfail, input int phb);
    for (int c = 0; c < len; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        a_succ[c][i] = ($urandom_range(0, psucc - 1) == 0);
        a_fail[c][i] = ($urandom_range(0, pfail - 1) == 0);
        a_hb[c][i]   = ($urandom_range(0, phb - 1) == 0);
      end
    end
  endtask

  initial begin
    bit     v, p;
    longint dcc;
    int     r, ch;

    // Pass once both masked channels have reported; unmasked failures and
    // a HOLD-time success are ignored.
    clear_stim(60);
    rand_noise(60, 1000000, 1000000, 2);
    a_succ[3] = 4'b0010; a_succ[20] = 4'b0001; a_succ[30] = 4'b0010;
    a_fail[25] = 4'b1100;
    g_mask = 4'b0011; g_max = 0; g_wdl = 0; g_dump = 12;
    run_test(60, -1, 1, 31, 1, 0, 0);

    // Simultaneous failures: lowest index reported, failure beats success.
    clear_stim(60);
    a_fail[15] = 4'b0110; a_succ[15] = 4'b1000;
    a_succ[10] = 4'b0111;
    g_mask = 4'b1111; g_max = 0; g_wdl = 0; g_dump = 500;
    run_test(60, -1, 1, 16, 0, 1, 1);

    // Timeout at 100 with cycle_count frozen afterwards.
    clear_stim(200);
    a_succ[20] = 4'b0001;
    g_mask = 4'b0011; g_max = 100; g_wdl = 0; g_dump = 12;
    run_test(200, -1, 1, 101, 0, 2, 0);

    // No mask, no timeout: never finishes.
    clear_stim(10000);
    rand_noise(10000, 7, 11, 3);
    g_mask = 4'b0000; g_max = 0; g_wdl = 0; g_dump = 9000;
    run_test(10000, -1, 0, 0, 0, 0, 0);

    // Watchdog: ch3 goes silent after cycle 8, ch0 keeps beating every 4.
    clear_stim(60);
    for (int c = 0; c < 60; c++) begin
      if (c % 4 == 0) a_hb[c][0] = 1'b1;
      if (c % 4 == 0 && c < 10) a_hb[c][3] = 1'b1;
    end
    a_succ[9] = 4'b0001;
    g_mask = 4'b1001; g_max = 0; g_wdl = 5; g_dump = 200;
    run_test(60, -1, 1, 15, 0, 3, 3);

    // Heartbeat every 5th cycle with limit 5 never fires; ends by timeout.
    clear_stim(300);
    for (int c = 0; c < 300; c++) if (c % 5 == 0) a_hb[c] = 4'b1111;
    g_mask = 4'b1111; g_max = 200; g_wdl = 5; g_dump = 0;
    run_test(300, -1, 1, 201, 0, 2, 0);

    // Abort mid-RUN with ch0 success latched; the latch must not survive.
    clear_stim(60);
    a_succ[20] = 4'b0001;
    g_mask = 4'b0011; g_max = 0; g_wdl = 0; g_dump = 12;
    run_test(60, 40, 0, 0, 0, 0, 0);
    clear_stim(120);
    a_succ[25] = 4'b0010;
    g_max = 60;
    run_test(120, -1, 1, 61, 0, 2, 0);

    // Randomized scenarios scored by the reference model.
    for (int t = 0; t < 8; t++) begin
      clear_stim(220);
      rand_noise(220, 40, 150, 2);
      g_mask = 4'($urandom_range(0, 15));
      g_max  = 64'($urandom_range(30, 180));
      g_wdl  = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(3, 8));
      g_dump = 64'($urandom_range(0, 80));
      model(220, v, dcc, p, r, ch);
      run_test(220, -1, v, dcc, p, r, ch);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule
